mem_port_arbiter: RTL and testbench

Shares the core's single-port 64 KiB unified memory between the instruction-fetch requester and the load/store requester, so the core can move from a combinational dual-read memory to one physical SRAM port. The block arbitrates round-robin, range- and alignment-checks each access, holds the memory command until the memory accepts it, and returns a registered response to the owning requester. It sits between the core's fetch/LSU logic and the memory macro.

---
 rtl/octonyte_mem_pkg.sv | 42 ++++
 rtl/mem_rr_arb2.sv | 49 ++++
 rtl/mem_port_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/octonyte_mem_pkg.sv
// ---------------------------------------------------------------------------
// octonyte_mem_pkg
//
// Shared definitions for the unified-memory port arbiter:
//   MEM_ADDR_BASE   byte address of memory word 0
//   MEM_AW_DEFAULT  default word-address width (2^14 words = 64 KiB)
//   arb_state_t     arbiter FSM states
//   req_id_t        requester identifiers; the value is also the bit index
//                   of that requester in the arbiter req/gnt vectors
//   in_window()     byte-address range check against the memory window
// ---------------------------------------------------------------------------
package octonyte_mem_pkg;

    localparam logic [31:0] MEM_ADDR_BASE  = 32'h8000_0000;
    localparam int          MEM_AW_DEFAULT = 14;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MEM  = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    typedef enum logic {
        REQ_IF = 1'b0,
        REQ_D  = 1'b1
    } req_id_t;

    // True when addr lies in [base, base + 4*2^aw). The comparison is done
    // in 33 bits so a window that ends exactly at 2^32 cannot wrap.
    function automatic logic in_window(input logic [31:0] addr,
                                       input logic [31:0] base,
                                       input int          aw);
        logic [32:0] a;
        logic [32:0] lo;
        logic [32:0] hi;
        a  = {1'b0, addr};
        lo = {1'b0, base};
        hi = lo + (33'd4 << aw);
        return (a >= lo) && (a < hi);
    endfunction

endpackage

// File: rtl/mem_rr_arb2.sv
// ---------------------------------------------------------------------------
// mem_rr_arb2
//
// Two-requester round-robin arbiter. The grant is purely combinational from
// the request vector and the last-grant register; the register only moves
// when the parent reports that the granted request was accepted.
//
// Ports:
//   clock   in   rising-edge clock
//   reset   in   synchronous active-high reset (last grant -> fetch)
//   req     in   [1:0] request vector, bit REQ_IF = fetch, bit REQ_D = data
//   accept  in   granted request was taken this cycle
//   gnt     out  [1:0] one-hot grant (all zero when nothing requests)
// ---------------------------------------------------------------------------
module mem_rr_arb2
    import octonyte_mem_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] gnt
);

    req_id_t last_gnt;

    // A lone requester always wins; on a tie the one that was not granted
    // last time wins, which makes data the first tie winner after reset.
    always_comb begin
        gnt = 2'b00;
        unique case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (last_gnt == REQ_IF) ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
    end

    // The pointer only follows real acceptances, so a grant that is shown
    // but not taken does not cost the other requester its turn.
    always_ff @(posedge clock) begin
        if (reset) begin
            last_gnt <= REQ_IF;
        end else if (accept && (gnt != 2'b00)) begin
            last_gnt <= gnt[1] ? REQ_D : REQ_IF;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-port SRAM between the instruction-fetch requester and
// the load/store requester. One access is in flight at a time: a request is
// accepted in IDLE, range/alignment checked, presented to the memory in MEM
// until the memory accepts it, and answered for exactly one cycle in RESP.
// Bad addresses skip MEM and are answered with err=1 and zero data.
//
// Parameters:
//   ADDR_BASE   byte address of memory word 0
//   MEM_AW      memory word-address width (window = 4*2^MEM_AW bytes)
//
// Ports:
//   clock, reset                         clock / synchronous active-high reset
//   if_req_valid/ready/addr              fetch read request
//   if_rsp_valid/rdata/err               fetch response
//   d_req_valid/ready/addr/we/wstrb/wdata  data request
//   d_rsp_valid/rdata/err                data response
//   mem_en/we/addr/wdata                 memory command
//   mem_ready, mem_rdata                 memory accept / read data (valid the
//                                        cycle after mem_en && mem_ready)
// ---------------------------------------------------------------------------
module mem_port_arbiter
    import octonyte_mem_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE = MEM_ADDR_BASE,
    parameter int          MEM_AW    = MEM_AW_DEFAULT
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              if_req_valid,
    output logic              if_req_ready,
    input  logic [31:0]       if_req_addr,
    output logic              if_rsp_valid,
    output logic [31:0]       if_rsp_rdata,
    output logic              if_rsp_err,

    input  logic              d_req_valid,
    output logic              d_req_ready,
    input  logic [31:0]       d_req_addr,
    input  logic              d_req_we,
    input  logic [3:0]        d_req_wstrb,
    input  logic [31:0]       d_req_wdata,
    output logic              d_rsp_valid,
    output logic [31:0]       d_rsp_rdata,
    output logic              d_rsp_err,

    output logic              mem_en,
    output logic [3:0]        mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ready,
    input  logic [31:0]       mem_rdata
);

    arb_state_t state;
    arb_state_t state_next;

    logic [1:0]        gnt;
    logic              accept;
    logic              sel_d;
    logic [31:0]       sel_addr;
    logic [31:0]       sel_offset;
    logic [MEM_AW-1:0] sel_word;
    logic              sel_err;

    req_id_t           owner_q;
    logic [MEM_AW-1:0] word_q;
    logic              we_q;
    logic [3:0]        wstrb_q;
    logic [31:0]       wdata_q;
    logic              err_q;

    mem_rr_arb2 u_arb (
        .clock  (clock),
        .reset  (reset),
        .req    ({d_req_valid, if_req_valid}),
        .accept (accept),
        .gnt    (gnt)
    );

    // Acceptance can only happen in IDLE; whenever anything is valid there,
    // the arbiter grants someone and the grant is the acceptance.
    assign accept = (state == IDLE) && (if_req_valid || d_req_valid);
    assign sel_d  = gnt[1];

    // Address decode of the winning request. The window offset is kept in
    // full width and truncated after the byte-to-word shift; its upper bits
    // are only meaningful for in-range addresses, which is all that reaches
    // the memory.
    assign sel_addr   = sel_d ? d_req_addr : if_req_addr;
    assign sel_offset = sel_addr - ADDR_BASE;
    assign sel_word   = MEM_AW'(sel_offset >> 2);
    assign sel_err    = (sel_addr[1:0] != 2'b00) ||
                        !in_window(sel_addr, ADDR_BASE, MEM_AW);

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Capture the accepted request. Fetch has no write side, so its write
    // enable, strobes and data are forced to zero.
    always_ff @(posedge clock) begin
        if (reset) begin
            owner_q <= REQ_IF;
            word_q  <= '0;
            we_q    <= 1'b0;
            wstrb_q <= 4'b0000;
            wdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else if (accept) begin
            owner_q <= sel_d ? REQ_D : REQ_IF;
            word_q  <= sel_word;
            we_q    <= sel_d ? d_req_we    : 1'b0;
            wstrb_q <= sel_d ? d_req_wstrb : 4'b0000;
            wdata_q <= sel_d ? d_req_wdata : 32'h0;
            err_q   <= sel_err;
        end
    end

    // Next-state logic. Bad accesses go straight to RESP so the memory is
    // never touched; good ones wait in MEM for the memory to accept.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_next = sel_err ? RESP : MEM;
                end
            end
            MEM: begin
                if (mem_ready) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Output decode. Everything defaults to zero, which is also the reset
    // picture: memory command only in MEM, response only in RESP, readies
    // only in IDLE. Read data is passed straight from the memory in RESP,
    // since that is the cycle after the memory accepted the read.
    always_comb begin
        if_req_ready = 1'b0;
        d_req_ready  = 1'b0;
        if_rsp_valid = 1'b0;
        if_rsp_rdata = 32'h0;
        if_rsp_err   = 1'b0;
        d_rsp_valid  = 1'b0;
        d_rsp_rdata  = 32'h0;
        d_rsp_err    = 1'b0;
        mem_en       = 1'b0;
        mem_we       = 4'b0000;
        mem_addr     = '0;
        mem_wdata    = 32'h0;
        unique case (state)
            IDLE: begin
                if_req_ready = gnt[0];
                d_req_ready  = gnt[1];
            end
            MEM: begin
                mem_en    = 1'b1;
                mem_we    = we_q ? wstrb_q : 4'b0000;
                mem_addr  = word_q;
                mem_wdata = wdata_q;
            end
            RESP: begin
                if (owner_q == REQ_D) begin
                    d_rsp_valid = 1'b1;
                    d_rsp_err   = err_q;
                    d_rsp_rdata = (err_q || we_q) ? 32'h0 : mem_rdata;
                end else begin
                    if_rsp_valid = 1'b1;
                    if_rsp_err   = err_q;
                    if_rsp_rdata = err_q ? 32'h0 : mem_rdata;
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Drives mem_port_arbiter against a behavioural SRAM, with a transaction-
// level reference model of the arbiter's rules that predicts every output
// on every cycle. Directed sequences with literal expectations come first,
// followed by randomized traffic with occasional resets.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int          AW    = 14;
    localparam int          WORDS = 1 << AW;

    logic          clock;
    logic          reset;
    logic          if_req_valid;
    logic          if_req_ready;
    logic [31:0]   if_req_addr;
    logic          if_rsp_valid;
    logic [31:0]   if_rsp_rdata;
    logic          if_rsp_err;
    logic          d_req_valid;
    logic          d_req_ready;
    logic [31:0]   d_req_addr;
    logic          d_req_we;
    logic [3:0]    d_req_wstrb;
    logic [31:0]   d_req_wdata;
    logic          d_rsp_valid;
    logic [31:0]   d_rsp_rdata;
    logic          d_rsp_err;
    logic          mem_en;
    logic [3:0]    mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          mem_ready;
    logic [31:0]   mem_rdata;

    int vectors;
    int miscompares;

    mem_port_arbiter #(
        .ADDR_BASE (BASE),
        .MEM_AW    (AW)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .if_req_valid (if_req_valid),
        .if_req_ready (if_req_ready),
        .if_req_addr  (if_req_addr),
        .if_rsp_valid (if_rsp_valid),
        .if_rsp_rdata (if_rsp_rdata),
        .if_rsp_err   (if_rsp_err),
        .d_req_valid  (d_req_valid),
        .d_req_ready  (d_req_ready),
        .d_req_addr   (d_req_addr),
        .d_req_we     (d_req_we),
        .d_req_wstrb  (d_req_wstrb),
        .d_req_wdata  (d_req_wdata),
        .d_rsp_valid  (d_rsp_valid),
        .d_rsp_rdata  (d_rsp_rdata),
        .d_rsp_err    (d_rsp_err),
        .mem_en       (mem_en),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_ready    (mem_ready),
        .mem_rdata    (mem_rdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural SRAM driven only by the DUT's memory pins.
    logic [31:0] sram [0:WORDS-1];

    always @(posedge clock) begin
        if (mem_en && mem_ready) begin
            mem_rdata <= sram[mem_addr];
            for (int b = 0; b < 4; b++) begin
                if (mem_we[b]) sram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
    end

    // Reference model: one pending transaction plus two flags saying whether
    // it is still waiting for the memory or is being answered this cycle.
    typedef struct {
        bit          owner_d;
        bit          err;
        bit          we;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        int unsigned word;
        logic [31:0] rdata;
    } txn_t;

    logic [31:0] ref_mem [0:WORDS-1];
    txn_t        cur;
    bit          m_access;
    bit          m_resp;
    bit          m_last_d;
    bit          check_en;
    bit          pick_d;
    logic [31:0] pick_addr;

    function automatic bit addr_bad(input logic [31:0] a);
        longint unsigned a64;
        longint unsigned lo;
        longint unsigned hi;
        a64 = a;
        lo  = BASE;
        hi  = lo + 4 * longint'(WORDS);
        return (a % 4 != 0) || (a64 < lo) || (a64 >= hi);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old_w,
                                          input logic [31:0] new_w,
                                          input logic [3:0]  strb);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) r[8*b +: 8] = new_w[8*b +: 8];
        end
        return r;
    endfunction

    always @(posedge clock) begin
        if (reset) begin
            if (m_access && mem_ready && cur.we)
                ref_mem[cur.word] = merge(ref_mem[cur.word], cur.wdata, cur.wstrb);
            m_access = 1'b0;
            m_resp   = 1'b0;
            m_last_d = 1'b0;
            check_en = 1'b1;
        end else if (m_resp) begin
            m_resp = 1'b0;
        end else if (m_access) begin
            if (mem_ready) begin
                cur.rdata = ref_mem[cur.word];
                if (cur.we) ref_mem[cur.word] = merge(ref_mem[cur.word], cur.wdata, cur.wstrb);
                m_access = 1'b0;
                m_resp   = 1'b1;
            end
        end else if (if_req_valid || d_req_valid) begin
            pick_d      = d_req_valid && (!if_req_valid || !m_last_d);
            m_last_d    = pick_d;
            pick_addr   = pick_d ? d_req_addr : if_req_addr;
            cur.owner_d = pick_d;
            cur.err     = addr_bad(pick_addr);
            cur.we      = pick_d ? d_req_we : 1'b0;
            cur.wstrb   = pick_d ? d_req_wstrb : 4'b0000;
            cur.wdata   = pick_d ? d_req_wdata : 32'h0;
            cur.word    = (pick_addr - BASE) / 4;
            cur.rdata   = 32'h0;
            if (cur.err) m_resp = 1'b1;
            else         m_access = 1'b1;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Per-cycle comparison of every DUT output against the model.
    bit          busy;
    bit          e_ifr;
    bit          e_dr;
    logic [31:0] e_rdata;

    always @(negedge clock) begin
        if (check_en) begin
            busy    = m_access || m_resp;
            e_ifr   = !busy && if_req_valid && (!d_req_valid || m_last_d);
            e_dr    = !busy && d_req_valid && (!if_req_valid || !m_last_d);
            e_rdata = (cur.err || cur.we) ? 32'h0 : cur.rdata;
            checkOutput("if_req_ready", 32'(if_req_ready), 32'(e_ifr));
            checkOutput("d_req_ready",  32'(d_req_ready),  32'(e_dr));
            checkOutput("mem_en",    32'(mem_en),    32'(m_access));
            checkOutput("mem_we",    32'(mem_we),    m_access ? 32'(cur.we ? cur.wstrb : 4'b0) : 32'h0);
            checkOutput("mem_addr",  32'(mem_addr),  m_access ? (cur.word % WORDS) : 32'h0);
            checkOutput("mem_wdata", mem_wdata,      m_access ? cur.wdata : 32'h0);
            checkOutput("if_rsp_valid", 32'(if_rsp_valid), 32'(m_resp && !cur.owner_d));
            checkOutput("if_rsp_err",   32'(if_rsp_err),   32'(m_resp && !cur.owner_d && cur.err));
            checkOutput("if_rsp_rdata", if_rsp_rdata, (m_resp && !cur.owner_d) ? e_rdata : 32'h0);
            checkOutput("d_rsp_valid",  32'(d_rsp_valid),  32'(m_resp && cur.owner_d));
            checkOutput("d_rsp_err",    32'(d_rsp_err),    32'(m_resp && cur.owner_d && cur.err));
            checkOutput("d_rsp_rdata",  d_rsp_rdata,  (m_resp && cur.owner_d) ? e_rdata : 32'h0);
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idleInputs();
        if_req_valid = 1'b0;
        d_req_valid  = 1'b0;
        d_req_we     = 1'b0;
        d_req_wstrb  = 4'b0000;
        d_req_wdata  = 32'h0;
    endtask

    function automatic logic [31:0] randAddr();
        int unsigned r;
        r = $urandom_range(0, 9);
        if (r == 0) return BASE + ($urandom_range(0, 255) | 32'h1);
        if (r == 1) begin
            case ($urandom_range(0, 2))
                0:       return BASE - 32'h4;
                1:       return BASE + 32'h0001_0000;
                default: return $urandom & 32'h7FFF_FFFC;
            endcase
        end
        if (r == 2) return BASE + 32'h0000_FFFC;
        return BASE + 4 * $urandom_range(0, 63);
    endfunction

    task automatic applyStimulus();
        reset        = ($urandom_range(0, 199) == 0);
        if_req_valid = $urandom_range(0, 1) == 1;
        if_req_addr  = randAddr();
        d_req_valid  = $urandom_range(0, 1) == 1;
        d_req_addr   = randAddr();
        d_req_we     = $urandom_range(0, 1) == 1;
        d_req_wstrb  = 4'($urandom);
        d_req_wdata  = $urandom;
        mem_ready    = $urandom_range(0, 3) != 0;
    endtask

    logic [31:0] err_addrs [3];

    initial begin
        vectors     = 0;
        miscompares = 0;
        check_en    = 1'b0;
        m_access    = 1'b0;
        m_resp      = 1'b0;
        m_last_d    = 1'b0;
        mem_rdata   = 32'h0;
        for (int i = 0; i < WORDS; i++) begin
            sram[i]    = 32'h13 + 32'(i) * 32'h0101_0101;
            ref_mem[i] = 32'h13 + 32'(i) * 32'h0101_0101;
        end
        idleInputs();
        if_req_addr = BASE;
        d_req_addr  = BASE;
        mem_ready   = 1'b1;
        reset       = 1'b1;
        repeat (3) step();
        reset = 1'b0;

        // Reset picture.
        @(negedge clock);
        checkOutput("rst_mem_en", 32'(mem_en), 32'h0);
        checkOutput("rst_mem_addr", 32'(mem_addr), 32'h0);
        checkOutput("rst_d_rsp_valid", 32'(d_rsp_valid), 32'h0);

        // Tie right after reset: D, IF, D, IF.
        step();
        if_req_valid = 1'b1; if_req_addr = BASE + 32'h8;
        d_req_valid  = 1'b1; d_req_addr  = BASE + 32'h20;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            checkOutput("tie_d_ready",  32'(d_req_ready),  32'(k % 2 == 0));
            checkOutput("tie_if_ready", 32'(if_req_ready), 32'(k % 2 == 1));
            step();
            step();
            @(negedge clock);
            checkOutput("tie_d_rsp",  32'(d_rsp_valid),  32'(k % 2 == 0));
            checkOutput("tie_if_rsp", 32'(if_rsp_valid), 32'(k % 2 == 1));
            step();
        end
        idleInputs();

        // Single fetch of word 0.
        if_req_valid = 1'b1; if_req_addr = BASE;
        @(negedge clock);
        checkOutput("fetch_ready", 32'(if_req_ready), 32'h1);
        step();
        if_req_valid = 1'b0;
        @(negedge clock);
        checkOutput("fetch_mem_en", 32'(mem_en), 32'h1);
        checkOutput("fetch_mem_addr", 32'(mem_addr), 32'h0);
        step();
        @(negedge clock);
        checkOutput("fetch_rsp_valid", 32'(if_rsp_valid), 32'h1);
        checkOutput("fetch_rsp_rdata", if_rsp_rdata, 32'h0000_0013);
        checkOutput("fetch_rsp_err", 32'(if_rsp_err), 32'h0);
        step();

        // Byte write then read back.
        d_req_valid = 1'b1; d_req_addr = BASE + 32'h104;
        d_req_we = 1'b1; d_req_wstrb = 4'b0010; d_req_wdata = 32'hAABB_CCDD;
        @(negedge clock);
        checkOutput("wr_ready", 32'(d_req_ready), 32'h1);
        step();
        idleInputs();
        @(negedge clock);
        checkOutput("wr_mem_we", 32'(mem_we), 32'h2);
        checkOutput("wr_mem_addr", 32'(mem_addr), 32'd65);
        step();
        @(negedge clock);
        checkOutput("wr_rsp_valid", 32'(d_rsp_valid), 32'h1);
        checkOutput("wr_rsp_rdata", d_rsp_rdata, 32'h0);
        step();
        d_req_valid = 1'b1; d_req_addr = BASE + 32'h104;
        step();
        idleInputs();
        step();
        @(negedge clock);
        checkOutput("rd_rsp_valid", 32'(d_rsp_valid), 32'h1);
        checkOutput("rd_byte1", {24'h0, d_rsp_rdata[15:8]}, 32'h0000_00CC);
        step();

        // Error accesses: answered one cycle after accept, memory untouched.
        err_addrs[0] = 32'h8001_0000;
        err_addrs[1] = 32'h8000_0002;
        err_addrs[2] = 32'h7FFF_FFFC;
        for (int e = 0; e < 3; e++) begin
            d_req_valid = 1'b1; d_req_addr = err_addrs[e];
            step();
            idleInputs();
            @(negedge clock);
            checkOutput("err_rsp_valid", 32'(d_rsp_valid), 32'h1);
            checkOutput("err_rsp_err", 32'(d_rsp_err), 32'h1);
            checkOutput("err_mem_en", 32'(mem_en), 32'h0);
            step();
        end

        // Wait states: memory stalls for three cycles.
        mem_ready = 1'b0;
        d_req_valid = 1'b1; d_req_addr = BASE + 32'h40;
        step();
        idleInputs();
        if_req_valid = 1'b1; if_req_addr = BASE;
        for (int w = 0; w < 3; w++) begin
            @(negedge clock);
            checkOutput("ws_mem_en", 32'(mem_en), 32'h1);
            checkOutput("ws_mem_addr", 32'(mem_addr), 32'd16);
            checkOutput("ws_if_ready", 32'(if_req_ready), 32'h0);
            checkOutput("ws_d_ready", 32'(d_req_ready), 32'h0);
            step();
        end
        mem_ready = 1'b1;
        @(negedge clock);
        checkOutput("ws_no_early_rsp", 32'(d_rsp_valid), 32'h0);
        step();
        if_req_valid = 1'b0;
        @(negedge clock);
        checkOutput("ws_rsp_valid", 32'(d_rsp_valid), 32'h1);
        step();

        // Reset while in MEM: abandoned, then first tie goes to D.
        mem_ready = 1'b0;
        d_req_valid = 1'b1; d_req_addr = BASE + 32'h80;
        step();
        idleInputs();
        reset = 1'b1;
        step();
        reset = 1'b0;
        mem_ready = 1'b1;
        if_req_valid = 1'b1; if_req_addr = BASE + 32'h4;
        d_req_valid  = 1'b1; d_req_addr  = BASE + 32'h84;
        @(negedge clock);
        checkOutput("rstmid_mem_en", 32'(mem_en), 32'h0);
        checkOutput("rstmid_d_rsp", 32'(d_rsp_valid), 32'h0);
        checkOutput("rstmid_d_ready", 32'(d_req_ready), 32'h1);
        checkOutput("rstmid_if_ready", 32'(if_req_ready), 32'h0);
        step();
        idleInputs();
        step();
        step();

        // Randomized traffic.
        repeat (3000) begin
            applyStimulus();
            step();
        end
        reset = 1'b0;
        idleInputs();
        mem_ready = 1'b1;
        repeat (5) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
